priority_decoder_seq: RTL and testbench
=======================================

PRIORITY_DECODER_SEQ -- requirements
Module: priority_decoder_seq

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset; ports SHALL be listed clock and reset first.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset, sampled on the clk rising edge.
REQ-004 CODE  input  4  encoded request index: 0 = no request; 1..12 = bit (CODE-1) of the 12-bit vector; 13..15 = invalid.
REQ-005 CODE_VALID  input  1  CODE is presented this cycle.
REQ-006 CODE_LAST  input  1  qualifies CODE_VALID and marks the final code of a frame.
REQ-007 CODE_READY  output  1  the block accepts CODE this cycle.
REQ-008 ONEHOT  output  12  registered one-hot decode of the last accepted code.
REQ-009 VEC  output  12  reconstructed request vector of the completed frame.
REQ-010 VEC_VALID  output  1  VEC is valid and held until accepted.
REQ-011 VEC_READY  input  1  the consumer accepts VEC this cycle.
REQ-012 CNT  output  4  number of codes accepted in the frame currently shown on VEC.
REQ-013 ERR  output  1  sticky invalid-code flag; exists only under the configuration macro (REQ-032).

Function
REQ-014 A code SHALL be accepted in any cycle where CODE_VALID and CODE_READY are both 1.
REQ-015 CODE_READY SHALL be 1 in IDLE and COLLECT and 0 in EMIT.
REQ-016 The state machine SHALL have three states: IDLE, COLLECT and EMIT.
REQ-017 Transitions: IDLE->COLLECT on accept with CODE_LAST=0; IDLE or COLLECT->EMIT on accept with CODE_LAST=1; COLLECT->COLLECT on accept with CODE_LAST=0; EMIT->IDLE when VEC_READY=1; every other case holds the state.
REQ-018 On each accept, the accumulator SHALL take the value of the accumulator OR the decode of CODE; codes 0 and 13..15 SHALL contribute 0.
REQ-019 On each accept, ONEHOT SHALL take the decode of CODE one cycle later, all zeros for codes 0 and 13..15; ONEHOT SHALL otherwise hold.
REQ-020 On each accept, the frame counter SHALL increment by 1 and saturate at 15.
REQ-021 On an accept with CODE_LAST=1, VEC SHALL take the accumulator OR the decode of CODE, CNT SHALL take the final count, and VEC_VALID SHALL rise on the next cycle (one cycle of latency).
REQ-022 In EMIT, VEC_VALID SHALL stay 1 with VEC and CNT stable until VEC_READY=1.
REQ-023 Leaving EMIT SHALL clear VEC_VALID, the accumulator and the frame counter in that same edge; VEC and CNT SHALL hold their values.
REQ-024 Duplicate codes within a frame SHALL be idempotent on VEC but SHALL still be counted in CNT.
REQ-025 A single-code frame with CODE=0 and CODE_LAST=1 SHALL emit VEC=0 and CNT=1.
REQ-026 CODE_LAST SHALL be ignored when CODE_VALID=0.
REQ-027 Inputs presented during EMIT SHALL be ignored (not accepted).

Reset
REQ-028 When rst=1, the state SHALL become IDLE and the accumulator, frame counter, ONEHOT, VEC, CNT, VEC_VALID and ERR SHALL all become 0.
REQ-029 CODE_READY SHALL be 1 in the first cycle after rst deasserts.
REQ-030 rst asserted mid-frame or during EMIT SHALL discard the frame; no VEC_VALID pulse SHALL follow.
REQ-031 rst SHALL take priority over any simultaneous accept or VEC_READY.

Configuration
REQ-032 The macro INVALID_CODE_ERR_EN SHALL control the ERR port and its logic.
REQ-033 With INVALID_CODE_ERR_EN defined, ERR SHALL set on any accepted code 13..15 and SHALL clear only on rst; the invalid code still contributes 0 to the vector.
REQ-034 Without INVALID_CODE_ERR_EN, the ERR port and its logic SHALL be absent and invalid codes SHALL be silently treated as 0.

Verification
REQ-035 Reset, then codes 12 and 5, the second with LAST, VEC_READY=1 -> VEC=12'b100000010000, CNT=2, VEC_VALID high for exactly 1 cycle.
REQ-036 Single code 9 with LAST -> ONEHOT=12'b000100000000 one cycle later; VEC=12'b000100000000, CNT=1.
REQ-037 Codes 3, 1, 3 (last), VEC_READY held 0 for 5 cycles -> VEC=12'b000000000101, CNT=3, VEC_VALID and CODE_READY=0 held for all 5 cycles; the block returns to IDLE the cycle after VEC_READY=1.
REQ-038 Code 0 with LAST -> VEC=0, CNT=1; then 16 codes of 1 (last on the 16th) -> VEC=12'b000000000001, CNT=15 (saturated).
REQ-039 Code 14 mid-frame -> ERR=1 and stays 1 after the frame completes (with the macro); VEC is unaffected; ERR=0 again only after rst.
REQ-040 rst pulse after two codes are accepted -> no VEC_VALID; the next frame, code 2 with LAST, gives VEC=12'b000000000010, CNT=1.

Source files
------------

// File: rtl/priority_decoder_seq_if.sv
// Code-in / vector-out handshake bundle for priority_decoder_seq.
// ERR is present only when INVALID_CODE_ERR_EN is defined.
interface priority_decoder_seq_if;
   logic [3:0]  CODE;
   logic        CODE_VALID;
   logic        CODE_LAST;
   logic        CODE_READY;
   logic [11:0] ONEHOT;
   logic [11:0] VEC;
   logic        VEC_VALID;
   logic        VEC_READY;
   logic [3:0]  CNT;
`ifdef INVALID_CODE_ERR_EN
   logic        ERR;

   modport master (
      output CODE, CODE_VALID, CODE_LAST, VEC_READY,
      input  CODE_READY, ONEHOT, VEC, VEC_VALID, CNT, ERR
   );

   modport slave (
      input  CODE, CODE_VALID, CODE_LAST, VEC_READY,
      output CODE_READY, ONEHOT, VEC, VEC_VALID, CNT, ERR
   );
`else
   modport master (
      output CODE, CODE_VALID, CODE_LAST, VEC_READY,
      input  CODE_READY, ONEHOT, VEC, VEC_VALID, CNT
   );

   modport slave (
      input  CODE, CODE_VALID, CODE_LAST, VEC_READY,
      output CODE_READY, ONEHOT, VEC, VEC_VALID, CNT
   );
`endif
endinterface

// File: rtl/priority_decoder_seq.sv
// Collects a frame of encoded request indices into a 12-bit request vector.
// Optional sticky invalid-code flag ERR is enabled by defining INVALID_CODE_ERR_EN.
module priority_decoder_seq (
   input logic                  clk,
   input logic                  rst,
   priority_decoder_seq_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      EMIT    = 2'd2
   } state_t;

   state_t      state;
   state_t      state_next;
   logic        ready;
   logic        accept;
   logic        release_vec;
   logic [11:0] code_dec;
   logic [11:0] acc;
   logic [3:0]  frame_cnt;
   logic [3:0]  frame_cnt_inc;
   logic [11:0] onehot;
   logic [11:0] vec;
   logic [3:0]  cnt;
   logic        vec_valid;

   // Codes outside 1..12 (including 0) decode to nothing.
   function automatic logic [11:0] decode(input logic [3:0] c);
      if (c >= 4'd1 && c <= 4'd12)
         decode = 12'd1 << (c - 4'd1);
      else
         decode = 12'd0;
   endfunction

   assign code_dec      = decode(bus.CODE);
   assign accept        = bus.CODE_VALID && ready;
   assign release_vec   = (state == EMIT) && bus.VEC_READY;
   assign frame_cnt_inc = (frame_cnt == 4'd15) ? 4'd15 : frame_cnt + 4'd1;

   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      ready      = 1'b1;
      case (state)
         IDLE, COLLECT: begin
            if (accept)
               state_next = bus.CODE_LAST ? EMIT : COLLECT;
         end
         EMIT: begin
            ready = 1'b0;
            if (bus.VEC_READY)
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Accept and release never coincide, since nothing is accepted in EMIT.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc       <= '0;
         frame_cnt <= '0;
         onehot    <= '0;
         vec       <= '0;
         cnt       <= '0;
         vec_valid <= 1'b0;
      end else if (accept) begin
         acc       <= acc | code_dec;
         frame_cnt <= frame_cnt_inc;
         onehot    <= code_dec;
         if (bus.CODE_LAST) begin
            vec       <= acc | code_dec;
            cnt       <= frame_cnt_inc;
            vec_valid <= 1'b1;
         end
      end else if (release_vec) begin
         acc       <= '0;
         frame_cnt <= '0;
         vec_valid <= 1'b0;
      end
   end

`ifdef INVALID_CODE_ERR_EN
   logic err;

   always_ff @(posedge clk) begin
      if (rst)
         err <= 1'b0;
      else if (accept && bus.CODE >= 4'd13)
         err <= 1'b1;
   end

   assign bus.ERR = err;
`endif

   assign bus.CODE_READY = ready;
   assign bus.ONEHOT     = onehot;
   assign bus.VEC        = vec;
   assign bus.CNT        = cnt;
   assign bus.VEC_VALID  = vec_valid;

endmodule

// File: tb/tb_priority_decoder_seq.sv
// Scoreboard bench for priority_decoder_seq: directed frames push expected {VEC,CNT},
// a negedge monitor pops and compares on every VEC_VALID/VEC_READY handshake.
module tb_priority_decoder_seq;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   typedef struct packed {
      logic [11:0] vec;
      logic [3:0]  cnt;
   } exp_t;

   exp_t expQ[$];

   priority_decoder_seq_if bus ();

   priority_decoder_seq dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
      end
   endtask

   // Drive one code and let it be taken on the next rising edge.
   task automatic applyStimulus(input logic [3:0] code, input logic last);
      checkOutput("ready_before_code", {15'd0, bus.CODE_READY}, 16'd1);
      bus.CODE       = code;
      bus.CODE_LAST  = last;
      bus.CODE_VALID = 1'b1;
      @(posedge clk);
      #1;
      bus.CODE_VALID = 1'b0;
      bus.CODE_LAST  = 1'b0;
   endtask

   task automatic waitVec();
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (bus.VEC_VALID)
            seen = 1'b1;
      end
      if (!seen) begin
         checks++;
         failures++;
         $display("[TB] FAIL vec_valid_timeout actual=0 expected=1");
      end
      @(posedge clk);
      #1;
   endtask

   // Monitor: every completed handshake must match the oldest expected frame.
   always @(negedge clk) begin
      if (!rst && bus.VEC_VALID && bus.VEC_READY) begin
         if (expQ.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpected_vec actual=%h expected=none", bus.VEC);
         end else begin
            exp_t e;
            e = expQ.pop_front();
            checkOutput("sb_vec", {4'd0, bus.VEC}, {4'd0, e.vec});
            checkOutput("sb_cnt", {12'd0, bus.CNT}, {12'd0, e.cnt});
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL global_timeout actual=running expected=finished");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      checks         = 0;
      failures       = 0;
      rst            = 1'b1;
      bus.CODE       = 4'd0;
      bus.CODE_VALID = 1'b0;
      bus.CODE_LAST  = 1'b0;
      bus.VEC_READY  = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("rst_onehot", {4'd0, bus.ONEHOT}, 16'd0);
      checkOutput("rst_vec", {4'd0, bus.VEC}, 16'd0);
      checkOutput("rst_cnt", {12'd0, bus.CNT}, 16'd0);
      checkOutput("rst_vec_valid", {15'd0, bus.VEC_VALID}, 16'd0);
`ifdef INVALID_CODE_ERR_EN
      checkOutput("rst_err", {15'd0, bus.ERR}, 16'd0);
`endif
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      checkOutput("ready_after_rst", {15'd0, bus.CODE_READY}, 16'd1);

      // Codes 12 then 5 with LAST; VEC_VALID must last exactly one cycle.
      applyStimulus(4'd12, 1'b0);
      expQ.push_back('{vec: 12'b100000010000, cnt: 4'd2});
      applyStimulus(4'd5, 1'b1);
      @(negedge clk);
      checkOutput("f1_vec_valid_high", {15'd0, bus.VEC_VALID}, 16'd1);
      checkOutput("f1_onehot", {4'd0, bus.ONEHOT}, 16'h0010);
      @(negedge clk);
      checkOutput("f1_vec_valid_pulse", {15'd0, bus.VEC_VALID}, 16'd0);

      // Single code 9.
      expQ.push_back('{vec: 12'b000100000000, cnt: 4'd1});
      applyStimulus(4'd9, 1'b1);
      @(negedge clk);
      checkOutput("f2_onehot", {4'd0, bus.ONEHOT}, 16'h0100);
      @(posedge clk);
      #1;

      // Codes 3,1,3 with consumer stalled for 5 cycles; a code during EMIT is ignored.
      bus.VEC_READY = 1'b0;
      applyStimulus(4'd3, 1'b0);
      applyStimulus(4'd1, 1'b0);
      expQ.push_back('{vec: 12'b000000000101, cnt: 4'd3});
      applyStimulus(4'd3, 1'b1);
      bus.CODE       = 4'd7;
      bus.CODE_LAST  = 1'b1;
      bus.CODE_VALID = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checkOutput("f3_hold_valid", {15'd0, bus.VEC_VALID}, 16'd1);
         checkOutput("f3_hold_ready", {15'd0, bus.CODE_READY}, 16'd0);
         checkOutput("f3_hold_vec", {4'd0, bus.VEC}, 16'h0005);
         checkOutput("f3_hold_cnt", {12'd0, bus.CNT}, 16'd3);
         checkOutput("f3_hold_onehot", {4'd0, bus.ONEHOT}, 16'h0004);
      end
      @(posedge clk);
      #1;
      bus.CODE_VALID = 1'b0;
      bus.CODE_LAST  = 1'b0;
      bus.VEC_READY  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checkOutput("f3_idle_ready", {15'd0, bus.CODE_READY}, 16'd1);
      checkOutput("f3_idle_valid", {15'd0, bus.VEC_VALID}, 16'd0);
      checkOutput("f3_vec_holds", {4'd0, bus.VEC}, 16'h0005);
      checkOutput("f3_cnt_holds", {12'd0, bus.CNT}, 16'd3);

      // Code 0 alone, then 16 ones saturating the count.
      expQ.push_back('{vec: 12'd0, cnt: 4'd1});
      applyStimulus(4'd0, 1'b1);
      waitVec();
      expQ.push_back('{vec: 12'b000000000001, cnt: 4'd15});
      for (int i = 0; i < 16; i++)
         applyStimulus(4'd1, (i == 15));
      waitVec();

      // Invalid code 14 mid-frame contributes nothing to VEC.
      expQ.push_back('{vec: 12'b000000101000, cnt: 4'd3});
      applyStimulus(4'd4, 1'b0);
      applyStimulus(4'd14, 1'b0);
      applyStimulus(4'd6, 1'b1);
      waitVec();
      @(negedge clk);
`ifdef INVALID_CODE_ERR_EN
      checkOutput("err_sticky", {15'd0, bus.ERR}, 16'd1);
`endif

      // Reset mid-frame, with a simultaneous LAST code that must lose to reset.
      applyStimulus(4'd7, 1'b0);
      applyStimulus(4'd8, 1'b0);
      rst            = 1'b1;
      bus.CODE       = 4'd5;
      bus.CODE_LAST  = 1'b1;
      bus.CODE_VALID = 1'b1;
      @(posedge clk);
      #1;
      rst            = 1'b0;
      bus.CODE_VALID = 1'b0;
      bus.CODE_LAST  = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checkOutput("rst_discard_valid", {15'd0, bus.VEC_VALID}, 16'd0);
      end
      checkOutput("rst_discard_onehot", {4'd0, bus.ONEHOT}, 16'd0);
`ifdef INVALID_CODE_ERR_EN
      checkOutput("err_cleared", {15'd0, bus.ERR}, 16'd0);
`endif
      expQ.push_back('{vec: 12'b000000000010, cnt: 4'd1});
      applyStimulus(4'd2, 1'b1);
      waitVec();
      repeat (2) @(negedge clk);

      checkOutput("scoreboard_drained", expQ.size(), 16'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
